// File: rtl/ahb_arb_pkg.sv
// Shared types for the two-manager AHB-Lite data-memory arbiter.
// Build option: ARB_FIXED_PRIO_EN selects fixed M0 priority instead of round-robin.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // Widest address the buffered address phase can carry.
  localparam int unsigned ADDR_W_MAX = 32;

  typedef logic mgr_id_t;
  localparam mgr_id_t MGR_M0 = 1'b0;
  localparam mgr_id_t MGR_M1 = 1'b1;

  typedef struct packed {
    logic [ADDR_W_MAX-1:0] haddr;
    logic                  hwrite;
    logic [2:0]            hsize;
  } addr_phase_t;

endpackage

// File: rtl/ahb_arb_in_stage.sv
// One-entry address-phase buffer for a single manager port of ahb_dm_arbiter.
// Captures NONSEQ/SEQ address phases while the manager sees HREADY high and holds
// them, with a pending flag, until the arbiter commits the grant.
module ahb_arb_in_stage
  import ahb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic              hready,
  input  logic              grant,
  output logic              pend,
  output addr_phase_t       ap
);

  logic        pend_q, pend_d;
  addr_phase_t ap_q, ap_d;
  logic        capture;

  // IDLE and BUSY never enter the buffer.
  assign capture = hready && ((htrans == NONSEQ) || (htrans == SEQ));

  // Next buffer contents: grant clears, a fresh capture (re)fills.
  always_comb begin
    pend_d = pend_q;
    ap_d   = ap_q;
    if (grant) begin
      pend_d = 1'b0;
    end
    if (capture) begin
      pend_d             = 1'b1;
      ap_d.haddr         = '0;
      ap_d.haddr[ADDR_W-1:0] = haddr;
      ap_d.hwrite        = hwrite;
      ap_d.hsize         = hsize;
    end
  end

  // Buffer state register with synchronous reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend_q <= 1'b0;
      ap_q   <= '0;
    end else begin
      pend_q <= pend_d;
      ap_q   <= ap_d;
    end
  end

  assign pend = pend_q;
  assign ap   = ap_q;

endmodule

// File: rtl/ahb_dm_arbiter.sv
// Two-manager to one-subordinate AHB-Lite arbiter for the shared data memory.
// M0 is the processor data port, M1 the loader/DMA/debug requester. Each port has
// a one-entry address buffer; buffered requests are issued to the subordinate and
// the data-phase response is steered back to the owning manager.
// Build option: define ARB_FIXED_PRIO_EN to give M0 absolute priority on ties.
module ahb_dm_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [ADDR_W-1:0] M0_HADDR,
  input  logic [1:0]        M0_HTRANS,
  input  logic              M0_HWRITE,
  input  logic [2:0]        M0_HSIZE,
  input  logic [DATA_W-1:0] M0_HWDATA,
  output logic [DATA_W-1:0] M0_HRDATA,
  output logic              M0_HREADY,
  output logic              M0_HRESP,
  input  logic [ADDR_W-1:0] M1_HADDR,
  input  logic [1:0]        M1_HTRANS,
  input  logic              M1_HWRITE,
  input  logic [2:0]        M1_HSIZE,
  input  logic [DATA_W-1:0] M1_HWDATA,
  output logic [DATA_W-1:0] M1_HRDATA,
  output logic              M1_HREADY,
  output logic              M1_HRESP,
  output logic [ADDR_W-1:0] S_HADDR,
  output logic [1:0]        S_HTRANS,
  output logic              S_HWRITE,
  output logic [2:0]        S_HSIZE,
  output logic [DATA_W-1:0] S_HWDATA,
  input  logic [DATA_W-1:0] S_HRDATA,
  input  logic              S_HREADY,
  input  logic              S_HRESP
);

  logic        pend_m0, pend_m1;
  addr_phase_t ap_m0, ap_m1;
  logic        grant_m0, grant_m1;
  logic        own_m0, own_m1;
  logic        any_pend;
  mgr_id_t     sel;
  addr_phase_t sel_ap, out_ap;

  logic        dp_valid_q, dp_valid_d;
  mgr_id_t     dp_owner_q, dp_owner_d;
  mgr_id_t     rr_last_q, rr_last_d;
  addr_phase_t last_ap_q, last_ap_d;

  ahb_arb_in_stage #(
    .ADDR_W(ADDR_W)
  ) u_in_m0 (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .haddr  (M0_HADDR),
    .htrans (M0_HTRANS),
    .hwrite (M0_HWRITE),
    .hsize  (M0_HSIZE),
    .hready (M0_HREADY),
    .grant  (grant_m0),
    .pend   (pend_m0),
    .ap     (ap_m0)
  );

  ahb_arb_in_stage #(
    .ADDR_W(ADDR_W)
  ) u_in_m1 (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .haddr  (M1_HADDR),
    .htrans (M1_HTRANS),
    .hwrite (M1_HWRITE),
    .hsize  (M1_HSIZE),
    .hready (M1_HREADY),
    .grant  (grant_m1),
    .pend   (pend_m1),
    .ap     (ap_m1)
  );

  assign any_pend = pend_m0 || pend_m1;

  // Combinational grant; on a tie the manager not served last wins.
  always_comb begin
    sel = MGR_M0;
    if (pend_m0 && pend_m1) begin
`ifdef ARB_FIXED_PRIO_EN
      sel = MGR_M0;
`else
      sel = (rr_last_q == MGR_M0) ? MGR_M1 : MGR_M0;
`endif
    end else if (pend_m1) begin
      sel = MGR_M1;
    end
  end

  assign sel_ap   = (sel == MGR_M1) ? ap_m1 : ap_m0;
  assign grant_m0 = S_HREADY && any_pend && (sel == MGR_M0);
  assign grant_m1 = S_HREADY && any_pend && (sel == MGR_M1);

  // Grant is committed only when the subordinate accepts the address phase.
  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_owner_d = dp_owner_q;
    rr_last_d  = rr_last_q;
    last_ap_d  = last_ap_q;
    if (any_pend) begin
      last_ap_d = sel_ap;
    end
    if (S_HREADY) begin
      if (any_pend) begin
        dp_valid_d = 1'b1;
        dp_owner_d = sel;
        rr_last_d  = sel;
      end else begin
        dp_valid_d = 1'b0;
      end
    end
  end

  // Data-phase ownership and arbitration history; rr_last resets to M1 so M0 wins first.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid_q <= 1'b0;
      dp_owner_q <= MGR_M0;
      rr_last_q  <= MGR_M1;
      last_ap_q  <= '0;
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_owner_q <= dp_owner_d;
      rr_last_q  <= rr_last_d;
      last_ap_q  <= last_ap_d;
    end
  end

  // Address fields hold their last driven value while nothing is pending.
  assign out_ap   = any_pend ? sel_ap : last_ap_q;
  assign S_HTRANS = any_pend ? NONSEQ : IDLE;
  assign S_HADDR  = out_ap.haddr[ADDR_W-1:0];
  assign S_HWRITE = out_ap.hwrite;
  assign S_HSIZE  = out_ap.hsize;

  assign own_m0 = dp_valid_q && (dp_owner_q == MGR_M0);
  assign own_m1 = dp_valid_q && (dp_owner_q == MGR_M1);

  // The stalled owner keeps HWDATA stable, so a plain mux is enough.
  assign S_HWDATA = own_m1 ? M1_HWDATA : (own_m0 ? M0_HWDATA : '0);

  // Owner tracks the subordinate; a buffered manager stalls until its data phase.
  assign M0_HREADY = own_m0 ? S_HREADY : !pend_m0;
  assign M1_HREADY = own_m1 ? S_HREADY : !pend_m1;
  assign M0_HRESP  = own_m0 && S_HRESP;
  assign M1_HRESP  = own_m1 && S_HRESP;
  assign M0_HRDATA = dp_valid_q ? S_HRDATA : '0;
  assign M1_HRDATA = dp_valid_q ? S_HRDATA : '0;

endmodule
